exec_sequencer: RTL
===================

// Module: exec_sequencer
// PURPOSE
//   Instruction read/execute controller feeding the register/PC datapath. Reads the
//   8-bit instruction at PC, reads operands from R0..R3, computes the ALU result and
//   drives res_alu/res_dest/res_we for write-back, plus a pc_inc pulse to advance PC.
//   Supports single-step (one instruction per step key) and free-run until HLT.
// PARAMETERS
//   DW      8   datapath / instruction width (opcode[7:4], rd[3:2], rs[1:0])
//   RUN_DEF 0   value of run mode after reset (0 = single-step, 1 = free-run)
// PORTS
//   clk       in   1   system clock, all state on rising edge
//   clr       in   1   asynchronous, active-low reset
//   step      in   1   start request, level; rising edge detected internally
//   run_sel   in   1   1 = free-run, 0 = single-step (sampled in IDLE)
//   instr     in   DW  instruction ROM data at current PC (combinational, valid 1 cycle after PC changes)
//   R0..R3    in   DW  register file contents
//   res_alu   out  DW  write-back data (registered)
//   res_dest  out  2   write-back register index (registered)
//   res_we    out  1   write-back strobe, 1-cycle pulse
//   pc_inc    out  1   PC advance strobe, 1-cycle pulse
//   busy      out  1   1 in any state other than IDLE/HALT
//   halted    out  1   1 in HALT
//   state     out  3   current FSM state code, for display
// BEHAVIOUR
//   - Reset (clr=0): state=IDLE, res_alu=0, res_dest=0, res_we=0, pc_inc=0, flags=0,
//     edge detector cleared; reset mid-instruction abandons it with no write-back.
//   - States: IDLE=0 FETCH=1 DECODE=2 EXEC=3 WB=4 IMM=5 HALT=6.
//   - IDLE: step rising edge -> FETCH; run mode latched from run_sel.
//   - FETCH: latch instr into IR -> DECODE.
//   - DECODE: latch A=R[rd], B=R[rs]; opcode C (LDI) asserts pc_inc, -> IMM;
//     opcode F (HLT) -> HALT; else -> EXEC.
//   - IMM: wait 1 cycle for ROM, latch instr as immediate -> WB with res_alu=imm.
//   - EXEC: compute, 8-bit mod-256 arithmetic, result registered -> WB.
//     0 NOP(no we) 1 ADD A+B 2 SUB A-B 3 AND 4 OR 5 XOR 6 NOT ~B 7 SHL B<<1
//     8 SHR B>>1 (logical) 9 MOV B A INC B+1 B DEC B-1; D,E treated as NOP.
//   - WB: res_we=1 (0 for NOP/D/E), res_dest=rd, pc_inc=1; next state FETCH if
//     run mode else IDLE. Fetch-to-WB = 4 cycles (5 for LDI).
//   - res_alu/res_dest hold their last values outside WB; res_we/pc_inc never >1 cycle.
//   - Wrap: 0xFF+1 -> 0x00, 0x00-1 -> 0xFF; PC wrap is the PC block's concern.
//   - step held high or re-pressed while busy is ignored (no queued request).
//   - HALT: outputs frozen, pc_inc not asserted for HLT; exits only via clr.
// CONFIGURATION
//   EXEC_FLAGS_EN defined: adds outputs flag_z, flag_c (1 bit each), updated in WB
//   for ADD/SUB/INC/DEC/SHL/SHR (c = carry out / borrow / shifted-out bit, z =
//   result==0), logic ops update z and clear c, MOV/LDI/NOP keep both; reset 0.
//   Not defined: no flag ports or registers, behaviour otherwise identical.
// TESTING
//   - Reset: clr=0 mid-EXEC -> state=0, res_we=0, res_alu=0 immediately, no pc_inc.
//   - Single-step ADD R1,R2 (0x16), R1=0x05 R2=0x03 -> exactly one WB after 4 cycles:
//     res_alu=0x08, res_dest=1, res_we=1, pc_inc=1, then IDLE.
//   - LDI R3 (0xCC) then byte 0x5A -> two pc_inc pulses, res_alu=0x5A, res_dest=3.
//   - Wrap: INC with R0=0xFF -> res_alu=0x00 (flag_z=1, flag_c=1 with EXEC_FLAGS_EN);
//     DEC R0=0x00 -> 0xFF.
//   - Free-run program ADD,SUB,HLT -> two write-backs, halted=1, no further pc_inc
//     or res_we for 20 cycles; step presses ignored.
//   - step held high 10 cycles in single-step -> exactly one instruction executed.

Source files
------------

// File: rtl/exec_sequencer_if.sv
// Handshake/data bus between the execute sequencer (slave) and its PC/register-file datapath (master).
// The flag signals exist only when EXEC_FLAGS_EN is defined.
interface exec_sequencer_if #(
  parameter int DW = 8
);
  logic          step;
  logic          run_sel;
  logic [DW-1:0] instr;
  logic [DW-1:0] R0;
  logic [DW-1:0] R1;
  logic [DW-1:0] R2;
  logic [DW-1:0] R3;
  logic [DW-1:0] res_alu;
  logic [1:0]    res_dest;
  logic          res_we;
  logic          pc_inc;
  logic          busy;
  logic          halted;
  logic [2:0]    state;
`ifdef EXEC_FLAGS_EN
  logic          flag_z;
  logic          flag_c;

  modport master (
    output step, run_sel, instr, R0, R1, R2, R3,
    input  res_alu, res_dest, res_we, pc_inc, busy, halted, state, flag_z, flag_c
  );

  modport slave (
    input  step, run_sel, instr, R0, R1, R2, R3,
    output res_alu, res_dest, res_we, pc_inc, busy, halted, state, flag_z, flag_c
  );
`else
  modport master (
    output step, run_sel, instr, R0, R1, R2, R3,
    input  res_alu, res_dest, res_we, pc_inc, busy, halted, state
  );

  modport slave (
    input  step, run_sel, instr, R0, R1, R2, R3,
    output res_alu, res_dest, res_we, pc_inc, busy, halted, state
  );
`endif
endinterface

// File: rtl/exec_sequencer.sv
// Instruction fetch/decode/execute/write-back controller with single-step and free-run modes.
// Optional macro EXEC_FLAGS_EN adds zero/carry flags updated at write-back.
module exec_sequencer #(
  parameter int DW      = 8,
  parameter bit RUN_DEF = 1'b0
) (
  input  logic            clk,
  input  logic            clr,
  exec_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_IMM    = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8;
  localparam logic [3:0] OP_MOV = 4'h9;
  localparam logic [3:0] OP_INC = 4'hA;
  localparam logic [3:0] OP_DEC = 4'hB;
  localparam logic [3:0] OP_LDI = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;

  function automatic logic [DW-1:0] alu_f(input logic [3:0] op,
                                          input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    logic [DW-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~b;
      OP_SHL:  r = {b[DW-2:0], 1'b0};
      OP_SHR:  r = {1'b0, b[DW-1:1]};
      OP_MOV:  r = b;
      OP_INC:  r = b + DW'(1);
      OP_DEC:  r = b - DW'(1);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Only ADD..DEC produce a register write from EXEC; NOP and the unused D/E codes do not.
  function automatic logic writes_f(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_DEC);
  endfunction

  function automatic logic [DW-1:0] reg_sel_f(input logic [1:0] sel,
                                              input logic [DW-1:0] r0,
                                              input logic [DW-1:0] r1,
                                              input logic [DW-1:0] r2,
                                              input logic [DW-1:0] r3);
    logic [DW-1:0] r;
    case (sel)
      2'd0:    r = r0;
      2'd1:    r = r1;
      2'd2:    r = r2;
      default: r = r3;
    endcase
    return r;
  endfunction

  state_t        state_q, state_d;
  logic          step_q;
  logic          step_rise;
  logic          run_q, run_d;
  logic          imm_wait_q, imm_wait_d;
  logic [DW-1:0] ir_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [DW-1:0] res_alu_q, res_alu_d;
  logic [1:0]    res_dest_q, res_dest_d;
  logic          res_we_q, res_we_d;
  logic          pc_inc_q, pc_inc_d;
  logic [3:0]    op_ir;
  logic [3:0]    op_in;
  logic [1:0]    rd_ir;
  logic [1:0]    rs_ir;
  logic [DW-1:0] alu_res;

  assign op_ir     = ir_q[7:4];
  assign rd_ir     = ir_q[3:2];
  assign rs_ir     = ir_q[1:0];
  assign op_in     = bus.instr[7:4];
  assign step_rise = bus.step & ~step_q;
  assign alu_res   = alu_f(op_ir, a_q, b_q);

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (step_rise) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (op_ir == OP_LDI)      state_d = S_IMM;
        else if (op_ir == OP_HLT) state_d = S_HALT;
        else                      state_d = S_EXEC;
      end
      S_EXEC:   state_d = S_WB;
      S_IMM:    if (imm_wait_q) state_d = S_WB;
      S_WB:     state_d = run_q ? S_FETCH : S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic: strobes are registered so they are high exactly during the cycle they belong to
  always_comb begin
    res_we_d   = 1'b0;
    pc_inc_d   = 1'b0;
    res_alu_d  = res_alu_q;
    res_dest_d = res_dest_q;
    imm_wait_d = 1'b0;
    run_d      = run_q;
    unique case (state_q)
      S_IDLE:  if (step_rise) run_d = bus.run_sel;
      // LDI advances PC during DECODE so the immediate byte is on instr by the IMM latch cycle
      S_FETCH: pc_inc_d = (op_in == OP_LDI);
      S_EXEC: begin
        res_we_d   = writes_f(op_ir);
        pc_inc_d   = 1'b1;
        res_dest_d = rd_ir;
        if (writes_f(op_ir)) res_alu_d = alu_res;
      end
      S_IMM: begin
        imm_wait_d = 1'b1;
        if (imm_wait_q) begin
          res_we_d   = 1'b1;
          pc_inc_d   = 1'b1;
          res_alu_d  = bus.instr;
          res_dest_d = rd_ir;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      step_q     <= 1'b0;
      run_q      <= RUN_DEF;
      imm_wait_q <= 1'b0;
      res_alu_q  <= '0;
      res_dest_q <= 2'd0;
      res_we_q   <= 1'b0;
      pc_inc_q   <= 1'b0;
    end else begin
      step_q     <= bus.step;
      run_q      <= run_d;
      imm_wait_q <= imm_wait_d;
      res_alu_q  <= res_alu_d;
      res_dest_q <= res_dest_d;
      res_we_q   <= res_we_d;
      pc_inc_q   <= pc_inc_d;
    end
  end

  // Instruction and operand latches carry data only and need no reset
  always_ff @(posedge clk) begin
    if (state_q == S_FETCH) ir_q <= bus.instr;
    if (state_q == S_DECODE) begin
      a_q <= reg_sel_f(rd_ir, bus.R0, bus.R1, bus.R2, bus.R3);
      b_q <= reg_sel_f(rs_ir, bus.R0, bus.R1, bus.R2, bus.R3);
    end
  end

  assign bus.res_alu  = res_alu_q;
  assign bus.res_dest = res_dest_q;
  assign bus.res_we   = res_we_q;
  assign bus.pc_inc   = pc_inc_q;
  assign bus.busy     = (state_q != S_IDLE) && (state_q != S_HALT);
  assign bus.halted   = (state_q == S_HALT);
  assign bus.state    = state_q;

`ifdef EXEC_FLAGS_EN
  function automatic logic carry_f(input logic [3:0] op,
                                   input logic [DW-1:0] a,
                                   input logic [DW-1:0] b);
    logic [DW:0] sum;
    logic        c;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      OP_ADD:  c = sum[DW];
      OP_SUB:  c = (a < b);
      OP_INC:  c = &b;
      OP_DEC:  c = (b == '0);
      OP_SHL:  c = b[DW-1];
      OP_SHR:  c = b[0];
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  // Logic ops update Z and clear C; MOV, LDI and NOP leave both flags alone
  function automatic logic flag_upd_f(input logic [3:0] op);
    return writes_f(op) && (op != OP_MOV);
  endfunction

  logic flag_z_q, flag_c_q;
  logic fz_pend_q, fc_pend_q, fupd_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      fz_pend_q <= 1'b0;
      fc_pend_q <= 1'b0;
      fupd_q    <= 1'b0;
    end else begin
      if (state_q == S_EXEC) begin
        fz_pend_q <= (alu_res == '0);
        fc_pend_q <= carry_f(op_ir, a_q, b_q);
        fupd_q    <= flag_upd_f(op_ir);
      end else if (state_q == S_IMM) begin
        fupd_q    <= 1'b0;
      end
      if ((state_q == S_WB) && fupd_q) begin
        flag_z_q <= fz_pend_q;
        flag_c_q <= fc_pend_q;
      end
    end
  end

  assign bus.flag_z = flag_z_q;
  assign bus.flag_c = flag_c_q;
`endif

endmodule
